// File: rtl/md_unit_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, B, MDOp, Start, input Busy, HI, LO);
  modport slave  (input A, B, MDOp, Start, output Busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Fixed-latency MIPS multiply/divide unit with architectural HI/LO registers.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      reset,
  md_unit_if.slave md
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [63:0]   pend;
  logic          pend_valid;
  logic [31:0]   hi_q, lo_q;

  logic op_mul, op_div, op_sgn, op_mthi, op_mtlo, long_op;
`ifdef MDU_MADD_EN
  logic op_acc, op_sub;
`endif

  always_comb begin
    op_mul  = 1'b0;
    op_div  = 1'b0;
    op_sgn  = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
`ifdef MDU_MADD_EN
    op_acc  = 1'b0;
    op_sub  = 1'b0;
`endif
    case (md.MDOp)
      4'd1: begin op_mul = 1'b1; op_sgn = 1'b1; end
      4'd2: op_mul = 1'b1;
      4'd3: begin op_div = 1'b1; op_sgn = 1'b1; end
      4'd4: op_div = 1'b1;
      4'd5: op_mthi = 1'b1;
      4'd6: op_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      4'd7:  begin op_mul = 1'b1; op_sgn = 1'b1; op_acc = 1'b1; end
      4'd8:  begin op_mul = 1'b1; op_acc = 1'b1; end
      4'd9:  begin op_mul = 1'b1; op_sgn = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      4'd10: begin op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
      default: ;
    endcase
    long_op = op_mul | op_div;
  end

  // Low 64 bits of the product of sign/zero-extended operands is exact for both signednesses.
  logic [63:0] mul_a, mul_b, prod;
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [63:0] result;

  always_comb begin
    mul_a = {{32{op_sgn & md.A[31]}}, md.A};
    mul_b = {{32{op_sgn & md.B[31]}}, md.B};
    prod  = mul_a * mul_b;

    // Sign-magnitude division; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    div_zero = (md.B == '0);
    a_neg    = op_sgn & md.A[31];
    b_neg    = op_sgn & md.B[31];
    a_mag    = a_neg ? -md.A : md.A;
    b_mag    = div_zero ? 32'd1 : (b_neg ? -md.B : md.B);
    q_mag    = a_mag / b_mag;
    r_mag    = a_mag % b_mag;
    quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem      = a_neg ? -r_mag : r_mag;

    result = op_div ? {rem, quot} : prod;
`ifdef MDU_MADD_EN
    if (op_acc)
      result = op_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (md.Start && long_op) state_nx = RUN;
      RUN:  if (cnt <= CW'(1))       state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  logic accept, commit, hi_wr, lo_wr;

  always_comb begin
    md.Busy = (state == RUN);
    md.HI   = hi_q;
    md.LO   = lo_q;
    accept  = (state == IDLE) && md.Start && long_op;
    hi_wr   = (state == IDLE) && md.Start && op_mthi;
    lo_wr   = (state == IDLE) && md.Start && op_mtlo;
    commit  = (state == RUN) && (cnt <= CW'(1)) && pend_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      if (accept) begin
        pend       <= result;
        pend_valid <= !(op_div && div_zero);
        cnt        <= op_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
      end
      if (hi_wr) hi_q <= md.A;
      if (lo_wr) lo_q <= md.A;
      if (commit) {hi_q, lo_q} <= pend;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random ops against a HI/LO model.
module tb_md_unit;
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk = 1'b0;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;

  logic [31:0] hi_m, lo_m;

  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one accepted op and its busy length.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int unsigned n, output logic [31:0] nhi, output logic [31:0] nlo);
    longint            sa, sb, q, r;
    longint unsigned   ua, ub, uq, ur, p;
    logic [63:0]       acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    acc = {hi_m, lo_m};
    nhi = hi_m;
    nlo = lo_m;
    n = 0;
    case (op)
      4'd1: begin n = MC; p = longint'(sa * sb); {nhi, nlo} = p; end
      4'd2: begin n = MC; p = ua * ub; {nhi, nlo} = p; end
      4'd3: begin
        n = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; nlo = q[31:0]; nhi = r[31:0]; end
      end
      4'd4: begin
        n = DC;
        if (b != 0) begin uq = ua / ub; ur = ua % ub; nlo = uq[31:0]; nhi = ur[31:0]; end
      end
      4'd5: nhi = a;
      4'd6: nlo = a;
`ifdef MDU_MADD_EN
      4'd7:  begin n = MC; p = longint'(sa * sb); {nhi, nlo} = acc + p; end
      4'd8:  begin n = MC; p = ua * ub;           {nhi, nlo} = acc + p; end
      4'd9:  begin n = MC; p = longint'(sa * sb); {nhi, nlo} = acc - p; end
      4'd10: begin n = MC; p = ua * ub;           {nhi, nlo} = acc - p; end
`endif
      default: ;
    endcase
  endtask

  // Called at a negedge; issues one op and follows it to completion.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit junk);
    int unsigned n;
    logic [31:0] nhi, nlo;
    model(op, a, b, n, nhi, nlo);
    bus.Start = 1'b1;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    for (int unsigned i = 0; i < n; i++) begin
      check("busy_run", 64'(bus.Busy), 64'd1);
      check("hold_hi", 64'(bus.HI), 64'(hi_m));
      check("hold_lo", 64'(bus.LO), 64'(lo_m));
      if (junk) begin
        bus.Start = 1'($urandom_range(0, 1));
        bus.MDOp  = 4'($urandom_range(0, 15));
        bus.A     = $urandom;
        bus.B     = $urandom;
      end
      @(negedge clk);
      bus.Start = 1'b0;
    end
    hi_m = nhi;
    lo_m = nlo;
    check("busy_done", 64'(bus.Busy), 64'd0);
    check("hi", 64'(bus.HI), 64'(hi_m));
    check("lo", 64'(bus.LO), 64'(lo_m));
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    reset     = 1'b1;
    bus.Start = 1'b0;
    bus.MDOp  = '0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hi_m = '0;
    lo_m = '0;
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_hi", 64'(bus.HI), 64'd0);
    check("rst_lo", 64'(bus.LO), 64'd0);

    run_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    check("mult_const", {32'(bus.HI), 32'(bus.LO)}, 64'hFFFFFFFF_FFFFFFFA);
    run_op(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
    check("multu_const", {32'(bus.HI), 32'(bus.LO)}, 64'h00000002_FFFFFFFA);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_const", {32'(bus.HI), 32'(bus.LO)}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(4'd4, 32'h00001234, 32'd0, 1'b1);
    check("divu_zero_const", {32'(bus.HI), 32'(bus.LO)}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    check("div_ovf_const", {32'(bus.HI), 32'(bus.LO)}, 64'h00000000_80000000);

    run_op(4'd5, 32'h12345678, 32'd0, 1'b0);
    run_op(4'd6, 32'h9ABCDEF0, 32'd0, 1'b0);
    check("mtx_const", {32'(bus.HI), 32'(bus.LO)}, 64'h12345678_9ABCDEF0);

    run_op(4'd5, 32'h00000000, 32'd0, 1'b0);
    run_op(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
    run_op(4'd8, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
    check("maddu_const", {32'(bus.HI), 32'(bus.LO)}, 64'h00000001_00000000);
`else
    check("maddu_off_const", {32'(bus.HI), 32'(bus.LO)}, 64'h00000000_FFFFFFFF);
`endif

    // Reset two cycles into a mult, with an ignored div start in between.
    run_op(4'd5, 32'hCAFEF00D, 32'd0, 1'b0);
    run_op(4'd6, 32'h0BADBEEF, 32'd0, 1'b0);
    bus.Start = 1'b1;
    bus.MDOp  = 4'd1;
    bus.A     = 32'h00000007;
    bus.B     = 32'h00000009;
    @(negedge clk);
    bus.Start = 1'b0;
    check("abort_busy", 64'(bus.Busy), 64'd1);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.MDOp  = 4'd3;
    bus.A     = 32'h00000100;
    bus.B     = 32'h00000003;
    @(negedge clk);
    bus.Start = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hi_m = '0;
    lo_m = '0;
    for (int unsigned i = 0; i < DC + 2; i++) begin
      check("abort_busy0", 64'(bus.Busy), 64'd0);
      check("abort_hi", 64'(bus.HI), 64'd0);
      check("abort_lo", 64'(bus.LO), 64'd0);
      @(negedge clk);
    end

    for (int unsigned t = 0; t < 80; t++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(op, a, b, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
